// File: rtl/aes_key_schedule.sv
// AES key expansion engine for AES-128 and AES-256.
//
// Expands the cipher key into 15 stored 128-bit round keys (rk[0..14]). One round key is
// produced per cycle using a single S-box word shared with the cipher datapath.
//
// Ports:
//   clk        - clock, all state on the rising edge
//   reset      - asynchronous active-high reset
//   key        - cipher key; AES-128 uses key[255:128] only
//   keylen     - 0 = AES-128, 1 = AES-256
//   init       - start key expansion (accepted in idle only)
//   round      - round key index to read
//   round_key  - stored round key for round (index 15 reads zero)
//   ready      - idle with all round keys valid
//   sboxw      - word sent to the shared S-box (zero outside generation)
//   new_sboxw  - substituted word returned combinationally by the S-box
module aes_key_schedule (
  input  logic           clk,
  input  logic           reset,
  input  logic [255:0]   key,
  input  logic           keylen,
  input  logic           init,
  input  logic [3:0]     round,
  output logic [127:0]   round_key,
  output logic           ready,
  output logic [31:0]    sboxw,
  input  logic [31:0]    new_sboxw
);

  typedef enum logic [1:0] {StIdle, StInit, StGen} state_e;

  state_e        state_q;
  logic [127:0]  rk_q [15];
  logic [3:0]    ctr_q;
  logic [7:0]    rcon_q;
  logic          mode_q;   // mode latched in INIT, governs the whole run
  logic          ready_q;

  logic [3:0]    ctr_m1, ctr_m2;
  logic [127:0]  prev1, prev2, p;
  logic [31:0]   t, w0, w1, w2, w3;
  logic [7:0]    rcon_next;
  logic          use_rot;
  logic          last_key;

  assign ctr_m1 = ctr_q - 4'd1;
  assign ctr_m2 = ctr_q - 4'd2;

  // Read muxes for the stored keys; unmatched indices (round 15) read zero.
  always_comb begin
    prev1     = '0;
    prev2     = '0;
    round_key = '0;
    for (int i = 0; i < 15; i++) begin
      if (ctr_m1 == 4'(i)) prev1 = rk_q[i];
      if (ctr_m2 == 4'(i)) prev2 = rk_q[i];
      if (round == 4'(i)) round_key = rk_q[i];
    end
  end

  // AES-128 chains from the previous key; AES-256 from the key two back, while the S-box
  // always substitutes the last word of the most recent key.
  assign p     = mode_q ? prev2 : prev1;
  assign sboxw = (state_q == StGen) ? prev1[31:0] : 32'h0;

  // AES-256 odd keys use SubWord only: no rotate, no rcon.
  assign use_rot = !mode_q || !ctr_q[0];
  assign t = use_rot ? ({new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_q, 24'h0}) : new_sboxw;

  assign w0 = p[127:96] ^ t;
  assign w1 = p[95:64]  ^ w0;
  assign w2 = p[63:32]  ^ w1;
  assign w3 = p[31:0]   ^ w2;

  // xtime in GF(2^8): 0x80 wraps to 0x1b.
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  assign last_key = mode_q ? (ctr_q == 4'd14) : (ctr_q == 4'd10);

  assign ready = ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ready_q <= 1'b1;
      ctr_q   <= 4'd0;
      rcon_q  <= 8'h01;
      mode_q  <= 1'b0;
      for (int i = 0; i < 15; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (init) begin
            state_q <= StInit;
            ready_q <= 1'b0;
          end
        end
        StInit: begin
          rk_q[0] <= key[255:128];
          if (keylen) begin
            rk_q[1] <= key[127:0];
            ctr_q   <= 4'd2;
          end else begin
            ctr_q   <= 4'd1;
          end
          mode_q  <= keylen;
          rcon_q  <= 8'h01;
          state_q <= StGen;
        end
        StGen: begin
          rk_q[ctr_q] <= {w0, w1, w2, w3};
          ctr_q       <= ctr_q + 4'd1;
          if (use_rot) begin
            rcon_q <= rcon_next;
          end
          if (last_key) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: table of key-expansion runs checked against an
// independent word-oriented FIPS-197 expansion model, plus directed init-glitch and
// mid-generation reset sequences.
module tb_aes_key_schedule;

  logic           clk = 1'b0;
  logic           reset;
  logic [255:0]   key;
  logic           keylen;
  logic           init;
  logic [3:0]     round;
  logic [127:0]   round_key;
  logic           ready;
  logic [31:0]    sboxw;
  logic [31:0]    new_sboxw;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_rk [15];

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0] KEY_FIPS128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_SEQ128  = {128'h000102030405060708090a0b0c0d0e0f,
                                          128'hffeeddccbbaa99887766554433221100};
  localparam logic [255:0] KEY_SEQ256  = {128'h000102030405060708090a0b0c0d0e0f,
                                          128'h101112131415161718191a1b1c1d1e1f};

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [2047:0] tab;
    tab = SBOX;
    return tab[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Combinational S-box shared with the DUT.
  always_comb new_sboxw = sub_word(sboxw);

  aes_key_schedule dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .keylen    (keylen),
    .init      (init),
    .round     (round),
    .round_key (round_key),
    .ready     (ready),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Classic word recurrence; only entries 0..Nr are overwritten so higher entries keep
  // whatever the previous run left, as the stored keys do.
  task automatic model_expand(input logic kl, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rc;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      temp = w[i - 1];
      if (i % nk == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = xtime(rc);
      end else if (nk == 8 && i % nk == 4) begin
        temp = sub_word(temp);
      end
      w[i] = w[i - nk] ^ temp;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 15; r++) begin
      round = 4'(r);
      #1;
      chk($sformatf("%s rk[%0d]", tag, r), round_key, exp_rk[r]);
    end
    round = 4'd15;
    #1;
    chk({tag, " rk15_zero"}, round_key, 128'h0);
    chk({tag, " sboxw_idle"}, {96'h0, sboxw}, 128'h0);
  endtask

  task automatic read_rk(input int idx, output logic [127:0] v);
    round = 4'(idx);
    #1;
    v = round_key;
  endtask

  // Starts a run and counts cycles of ready low after the accepting edge. glitch: cycle at
  // which init is re-pulsed with keylen flipped; abort: cycle at which reset is asserted.
  task automatic run_init(input logic kl, input logic [255:0] k, input int glitch,
                          input int abort, output int lat);
    @(negedge clk);
    keylen = kl;
    key    = k;
    init   = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    chk("ready_clear_on_accept", {127'h0, ready}, 128'h0);
    lat = 0;
    while (!ready && lat < 40) begin
      lat++;
      if (lat == abort) begin
        reset = 1'b1;
        #1;
        break;
      end
      if (lat == glitch) begin
        init   = 1'b1;
        keylen = ~keylen;
      end else begin
        init = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    init = 1'b0;
  endtask

  typedef struct {
    logic          kl;
    logic [255:0]  key;
    int            lat;
    int            idx_a;
    logic [127:0]  exp_a;
    int            idx_b;
    logic [127:0]  exp_b;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int lat;
    logic [127:0] v;

    vecs[0] = '{1'b0, KEY_FIPS128, 11, 1, 128'ha0fafe1788542cb123a339392a6c7605,
                10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{1'b0, KEY_SEQ128, 11, 0, 128'h000102030405060708090a0b0c0d0e0f,
                10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[2] = '{1'b1, KEY_SEQ256, 14, 1, 128'h101112131415161718191a1b1c1d1e1f,
                14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    // Back-to-back after AES-256: entries 11..14 must keep the AES-256 keys.
    vecs[3] = '{1'b0, KEY_FIPS128, 11, 1, 128'ha0fafe1788542cb123a339392a6c7605,
                10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    reset  = 1'b1;
    init   = 1'b0;
    key    = '0;
    keylen = 1'b0;
    round  = 4'd0;
    for (int r = 0; r < 15; r++) exp_rk[r] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {127'h0, ready}, 128'h1);
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 4; n++) begin
      run_init(vecs[n].kl, vecs[n].key, -1, -1, lat);
      chk($sformatf("vec%0d latency", n), 128'(lat), 128'(vecs[n].lat));
      read_rk(vecs[n].idx_a, v);
      chk($sformatf("vec%0d anchor rk[%0d]", n, vecs[n].idx_a), v, vecs[n].exp_a);
      read_rk(vecs[n].idx_b, v);
      chk($sformatf("vec%0d anchor rk[%0d]", n, vecs[n].idx_b), v, vecs[n].exp_b);
      model_expand(vecs[n].kl, vecs[n].key);
      check_all($sformatf("vec%0d", n));
    end

    // init re-pulsed mid-generation with keylen flipped: must be ignored.
    run_init(1'b0, KEY_FIPS128, 4, -1, lat);
    chk("glitch latency", 128'(lat), 128'd11);
    model_expand(1'b0, KEY_FIPS128);
    check_all("glitch");

    // Reset during GEN cycle 5 of an AES-128 run following an AES-256 run.
    run_init(1'b1, KEY_SEQ256, -1, -1, lat);
    model_expand(1'b1, KEY_SEQ256);
    check_all("pre_abort");
    run_init(1'b0, KEY_FIPS128, -1, 6, lat);
    chk("abort ready", {127'h0, ready}, 128'h1);
    for (int r = 0; r < 15; r++) exp_rk[r] = '0;
    check_all("abort");
    @(negedge clk);
    reset = 1'b0;
    run_init(1'b0, KEY_FIPS128, -1, -1, lat);
    chk("post_abort latency", 128'(lat), 128'd11);
    read_rk(10, v);
    chk("post_abort anchor rk[10]", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    model_expand(1'b0, KEY_FIPS128);
    check_all("post_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
